// File: rtl/maze_memory_if.sv
// Cell-access, row-load and row-dump signals shared between the maze store
// and whoever drives it (solver plus host, or a testbench).
interface maze_memory_if #(
    parameter int maze_width = 6
);
    localparam int n = 1 << maze_width;

    logic [maze_width-1:0]   row;
    logic [maze_width-1:0]   col;
    logic                    maze_oe;
    logic                    maze_we;
    logic                    maze_in;
    logic                    load_valid;
    logic                    load_ready;
    logic [n-1:0]            load_data;
    logic                    loaded;
    logic                    dump_req;
    logic                    dump_valid;
    logic                    dump_ready;
    logic [n-1:0]            dump_data;
    logic [2*maze_width:0]   visited_count;
    logic                    access_error;

    modport master (
        output row, col, maze_oe, maze_we, load_valid, load_data, dump_req, dump_ready,
        input  maze_in, load_ready, loaded, dump_valid, dump_data, visited_count, access_error
    );

    modport slave (
        input  row, col, maze_oe, maze_we, load_valid, load_data, dump_req, dump_ready,
        output maze_in, load_ready, loaded, dump_valid, dump_data, visited_count, access_error
    );
endinterface

// File: rtl/maze_memory.sv
// Maze wall map plus visited-path map: loaded row by row, served to the solver
// cell by cell, and dumped back row by row.
module maze_memory #(
    parameter int maze_width = 6
) (
    input logic           clk,
    input logic           rst,
    maze_memory_if.slave  bus
);
    localparam int n           = 1 << maze_width;
    localparam int count_width = 2 * maze_width + 1;
    localparam logic [maze_width-1:0] last_row = {maze_width{1'b1}};

    typedef enum logic [1:0] {LOAD, SERVE, DUMP} state_t;

    state_t                  state;
    logic [n-1:0]            wall_mem [n];
    logic [n-1:0]            path_mem [n];
    logic [maze_width-1:0]   load_ptr;
    logic [maze_width-1:0]   dump_ptr;
    logic [maze_width-1:0]   next_dump_ptr;
    logic                    maze_in_q;
    logic                    load_ready_q;
    logic                    loaded_q;
    logic                    dump_valid_q;
    logic [n-1:0]            dump_data_q;
    logic [count_width-1:0]  visited_count_q;
    logic                    access_error_q;
    logic                    wall_bit;
    logic                    path_bit;

    assign wall_bit      = wall_mem[bus.row][bus.col];
    assign path_bit      = path_mem[bus.row][bus.col];
    assign next_dump_ptr = dump_ptr + maze_width'(1);

    assign bus.maze_in       = maze_in_q;
    assign bus.load_ready    = load_ready_q;
    assign bus.loaded        = loaded_q;
    assign bus.dump_valid    = dump_valid_q;
    assign bus.dump_data     = dump_data_q;
    assign bus.visited_count = visited_count_q;
    assign bus.access_error  = access_error_q;

    // Map arrays are deliberately left out of reset; a reload rewrites every row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= LOAD;
            maze_in_q       <= 1'b1;
            load_ready_q    <= 1'b1;
            loaded_q        <= 1'b0;
            dump_valid_q    <= 1'b0;
            dump_data_q     <= '0;
            visited_count_q <= '0;
            access_error_q  <= 1'b0;
            load_ptr        <= '0;
            dump_ptr        <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.maze_oe || bus.maze_we)
                        access_error_q <= 1'b1;
                    if (bus.load_valid && load_ready_q) begin
                        wall_mem[load_ptr] <= bus.load_data;
                        path_mem[load_ptr] <= '0;
                        load_ptr           <= load_ptr + maze_width'(1);
                        if (load_ptr == last_row) begin
                            state        <= SERVE;
                            loaded_q     <= 1'b1;
                            load_ready_q <= 1'b0;
                        end
                    end
                end

                SERVE: begin
                    if (bus.maze_oe)
                        maze_in_q <= wall_bit;
                    // A read wins over a simultaneous write; the write is flagged and dropped.
                    if (bus.maze_oe && bus.maze_we) begin
                        access_error_q <= 1'b1;
                    end else if (bus.maze_we) begin
                        if (wall_bit) begin
                            access_error_q <= 1'b1;
                        end else if (!path_bit) begin
                            path_mem[bus.row][bus.col] <= 1'b1;
                            visited_count_q            <= visited_count_q + count_width'(1);
                        end
                    end
                    if (bus.dump_req) begin
                        state        <= DUMP;
                        dump_ptr     <= '0;
                        dump_valid_q <= 1'b1;
                        dump_data_q  <= path_mem[0];
                    end
                end

                DUMP: begin
                    if (bus.maze_oe || bus.maze_we)
                        access_error_q <= 1'b1;
                    if (dump_valid_q && bus.dump_ready) begin
                        if (dump_ptr == last_row) begin
                            dump_valid_q <= 1'b0;
                            state        <= SERVE;
                        end else begin
                            dump_ptr    <= next_dump_ptr;
                            dump_data_q <= path_mem[next_dump_ptr];
                        end
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_memory.sv
// Directed bench for maze_memory: load, reads, writes, dump, protocol errors
// and mid-operation resets, each step checked against hand-computed values.
module tb_maze_memory;
    localparam int maze_width = 6;
    localparam int n          = 1 << maze_width;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [n-1:0] exp_path [n];

    maze_memory_if #(.maze_width(maze_width)) bus ();

    maze_memory #(.maze_width(maze_width)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Walls on both border columns plus a diagonal wall at column r.
    function automatic logic [n-1:0] row_data(input int r);
        logic [n-1:0] d;
        d      = '0;
        d[0]   = 1'b1;
        d[n-1] = 1'b1;
        d[r]   = 1'b1;
        return d;
    endfunction

    task automatic load_beat(input int r);
        bus.load_valid = 1'b1;
        bus.load_data  = row_data(r);
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic access(input int r, input int c, input logic oe, input logic we);
        bus.row     = r[maze_width-1:0];
        bus.col     = c[maze_width-1:0];
        bus.maze_oe = oe;
        bus.maze_we = we;
        tick();
        bus.maze_oe = 1'b0;
        bus.maze_we = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_maze_in"},    bus.maze_in,       64'd1);
        check({tag, "_load_ready"}, bus.load_ready,    64'd1);
        check({tag, "_loaded"},     bus.loaded,        64'd0);
        check({tag, "_dump_valid"}, bus.dump_valid,    64'd0);
        check({tag, "_dump_data"},  bus.dump_data,     64'd0);
        check({tag, "_count"},      bus.visited_count, 64'd0);
        check({tag, "_error"},      bus.access_error,  64'd0);
    endtask

    initial begin
        int beat;
        int cyc;
        logic stalled;
        logic [n-1:0] held;

        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        bus.row        = '0;
        bus.col        = '0;
        bus.maze_oe    = 1'b0;
        bus.maze_we    = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.dump_req   = 1'b0;
        bus.dump_ready = 1'b0;
        for (int r = 0; r < n; r++) exp_path[r] = '0;

        tick();
        rst = 1'b0;
        check_reset_values("reset");

        for (int r = 0; r < n - 1; r++) load_beat(r);
        check("loaded_before_last", bus.loaded, 64'd0);
        load_beat(n - 1);
        check("loaded_after_last", bus.loaded, 64'd1);
        check("load_ready_after_last", bus.load_ready, 64'd0);
        check("count_after_load", bus.visited_count, 64'd0);

        access(5, 0, 1'b1, 1'b0);
        check("read_5_0_wall", bus.maze_in, 64'd1);
        access(5, 1, 1'b1, 1'b0);
        check("read_5_1_free", bus.maze_in, 64'd0);
        access(9, 9, 1'b0, 1'b0);
        check("hold_without_oe", bus.maze_in, 64'd0);
        access(9, 9, 1'b1, 1'b0);
        check("read_9_9_diag", bus.maze_in, 64'd1);
        access(9, 8, 1'b1, 1'b0);
        check("read_9_8_free", bus.maze_in, 64'd0);
        access(5, 63, 1'b1, 1'b0);
        check("read_5_63_border", bus.maze_in, 64'd1);

        access(5, 1, 1'b0, 1'b1);
        access(5, 1, 1'b0, 1'b1);
        access(5, 2, 1'b0, 1'b1);
        check("count_after_remark", bus.visited_count, 64'd2);
        check("error_after_free_writes", bus.access_error, 64'd0);
        access(5, 0, 1'b0, 1'b1);
        check("error_wall_write", bus.access_error, 64'd1);
        check("count_after_wall_write", bus.visited_count, 64'd2);
        access(0, 5, 1'b0, 1'b1);
        access(63, 62, 1'b0, 1'b1);
        check("count_after_corner_writes", bus.visited_count, 64'd4);
        exp_path[5]  = 64'h6;
        exp_path[0]  = 64'h20;
        exp_path[63] = 64'h4000_0000_0000_0000;

        bus.dump_req = 1'b1;
        tick();
        bus.dump_req = 1'b0;
        beat    = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (beat < n && cyc < 400) begin
            bus.dump_ready = (cyc % 3 != 1);
            if (stalled) begin
                check("dump_hold_valid", bus.dump_valid, 64'd1);
                check("dump_hold_data", bus.dump_data, held);
            end
            if (bus.dump_valid && bus.dump_ready) begin
                check($sformatf("dump_row_%0d", beat), bus.dump_data, exp_path[beat]);
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = bus.dump_valid;
                held    = bus.dump_data;
            end
            tick();
            cyc++;
        end
        bus.dump_ready = 1'b0;
        check("dump_beat_total", 64'(beat), 64'(n));
        check("dump_valid_after_last", bus.dump_valid, 64'd0);

        access(5, 1, 1'b1, 1'b0);
        check("serve_read_after_dump", bus.maze_in, 64'd0);
        access(10, 11, 1'b0, 1'b1);
        check("serve_write_after_dump", bus.visited_count, 64'd5);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("rst_serve");
        access(5, 1, 1'b1, 1'b0);
        check("oe_in_load_holds", bus.maze_in, 64'd1);
        check("oe_in_load_error", bus.access_error, 64'd1);

        for (int r = 0; r < 10; r++) load_beat(r);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("rst_mid_load");

        for (int r = 0; r < n - 1; r++) load_beat(r);
        check("reload_not_done_early", bus.loaded, 64'd0);
        load_beat(n - 1);
        check("reload_done", bus.loaded, 64'd1);

        access(9, 9, 1'b1, 1'b0);
        check("pre_simul_read", bus.maze_in, 64'd1);
        access(5, 3, 1'b1, 1'b1);
        check("simul_read_served", bus.maze_in, 64'd0);
        check("simul_not_marked", bus.visited_count, 64'd0);
        check("simul_error", bus.access_error, 64'd1);

        bus.dump_req = 1'b1;
        tick();
        bus.dump_req   = 1'b0;
        bus.dump_ready = 1'b1;
        check("dump2_first_valid", bus.dump_valid, 64'd1);
        tick();
        tick();
        tick();
        bus.dump_ready = 1'b0;
        check("dump2_mid_valid", bus.dump_valid, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("rst_mid_dump");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/maze_memory.md
# maze_memory

Behavioural-plus-synthesizable maze store that answers the maze solver's cell-access interface. It holds a 2^maze_width × 2^maze_width wall map and a matching visited-path map. A host loads the map row by row; the block then answers solver reads (`row`/`col`/`maze_oe` → registered `maze_in`) and records solver writes (`maze_we`) as visited cells. The path map can be dumped back row by row for checking. It sits opposite the solver in the maze top level and doubles as the testbench memory model.

## Interface
- `maze_width`, 6, coordinate width; the map is N×N with N = 2^maze_width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `row`, `col`  in  maze_width each  cell coordinates driven by the solver.
- `maze_oe`  in  1  read request for [row, col], sampled on `clk`.
- `maze_we`  in  1  mark-visited request for [row, col], sampled on `clk`.
- `maze_in`  out  1  registered read data: 1 = wall, 0 = free.
- `load_valid`  in  1  host row beat valid.
- `load_ready`  out  1  block accepts a load beat.
- `load_data`  in  N  one maze row; bit c = cell [row, c]; 1 = wall.
- `loaded`  out  1  all N rows loaded; the block is serving the solver.
- `dump_req`  in  1  request a path-map dump; sampled in SERVE only.
- `dump_valid`  out  1  dump beat valid.
- `dump_ready`  in  1  host accepts the dump beat.
- `dump_data`  out  N  path row; bit c = 1 if cell [row, c] was marked.
- `visited_count`  out  2·maze_width+1  number of distinct cells marked.
- `access_error`  out  1  sticky protocol-violation flag.

## Operation
- States: LOAD, SERVE, DUMP. Reset enters LOAD.
- **Reset values:** `maze_in`=1, `load_ready`=1, `loaded`=0, `dump_valid`=0, `dump_data`=0, `visited_count`=0, `access_error`=0, load and dump row pointers = 0.
- Map contents are not cleared by reset. Each path row is cleared when its wall row is loaded.
- **LOAD:**
  - Each cycle with `load_valid`&`load_ready`: wall[ptr] ← `load_data`, path[ptr] ← 0, ptr ← ptr+1.
  - When the beat at ptr = N−1 is accepted, go to SERVE: `loaded`=1, `load_ready`=0.
  - `maze_oe` or `maze_we` during LOAD: set `access_error`; the request is otherwise ignored and `maze_in` holds.
- **SERVE, read:** `maze_oe`=1 → `maze_in` ← wall[row][col]. `maze_in` holds its value when `maze_oe`=0.
- **SERVE, write:** `maze_we`=1 on a free cell whose path bit is 0 → set the path bit and increment `visited_count`.
  - Re-marking an already-visited cell: no change, no error.
  - `maze_we` on a wall cell: set `access_error`; the cell is not marked.
- **SERVE, simultaneous:** `maze_oe` and `maze_we` in the same cycle → the read is served, the write is dropped, `access_error` is set.
- **SERVE, dump entry:** `dump_req`=1 → go to DUMP with dump ptr = 0. An access in that same cycle is still served.
  - `dump_data` ← path[0] and `dump_valid`=1 from the next cycle.
- **DUMP:**
  - On `dump_valid`&`dump_ready`, advance the pointer and load the next row.
  - After row N−1 is accepted: `dump_valid`=0 next cycle, return to SERVE with the path map unchanged.
  - `maze_oe`/`maze_we` during DUMP: set `access_error` and ignore the request.
- **Coordinates:** all N×N coordinates are legal; border cells are ordinary cells. No wrap logic exists; the coordinate width exactly covers N.
- **`visited_count`:** maximum N² = 4096 for maze_width=6, which fits in 13 bits, so no saturation is needed.
- **Reload:** only via `rst`. After reset, `loaded`=0 and a full reload is required.

## Timing
- Read latency is 1 cycle: with `maze_oe` sampled at edge k, `maze_in` is valid after edge k and stable until the next served read. This matches a solver that asserts `oe` in one state and evaluates `maze_in` in the next.
- Writes take effect at the sampling edge. A read of the same cell one cycle later sees wall data only, since reads never return path bits. `visited_count` updates at the same edge as the write.
- Load throughput is 1 row/cycle. The minimum load is N cycles. `loaded` rises the cycle after the final accepted beat.
- Dump throughput is 1 row/cycle with `dump_ready` held high. `dump_data`/`dump_valid` hold while `dump_valid`&!`dump_ready`.
- `rst` has priority over every other input in the same cycle, including mid-LOAD and mid-DUMP. The block is in LOAD with reset values on the next cycle.
- `access_error` clears only on `rst`.

## Test plan
- **Reset then load:** reset, then 64 beats of `load_data`=0 with bit 0 and bit 63 set (walls at col 0 and 63). Require `load_ready`=0 and `loaded`=1 exactly one cycle after beat 64, and `visited_count`=0.
- **Reads:** read [5,0] then [5,1], each with `oe` for 1 cycle. Require `maze_in`=1 then 0, each one cycle after its `oe`; `maze_in` holds with `oe`=0.
- **Writes:** `we` at [5,1] twice, then at [5,2]. Require `visited_count`=2 and `access_error`=0. Then `we` at [5,0] (wall): `access_error`=1 and count stays 2.
- **Dump:** `dump_req` with `dump_ready` toggling 1,0,1. Require row 5 `dump_data`=0x6, data stable while not ready, 64 beats total, and return to SERVE.
- **Protocol errors:** `oe`&`we` together at [5,3] → read served, cell not marked, `access_error`=1. `oe` during LOAD → `access_error`=1 and `maze_in` unchanged.
- **Mid-operation reset:** assert `rst` mid-load (after beat 10) and again mid-dump (after beat 3). Require all outputs at reset values next cycle and a full reload needed before `loaded`=1.
